// File: rtl/se_sched_pkg.sv
// Shared types and default sizes for the SE pair scheduler.
// The report flags struct carries the two verdict bits presented with each report.
package se_sched_pkg;

   localparam int unsigned DefDataW   = 128;
   localparam int unsigned DefInstW   = 8;
   localparam int unsigned DefLatW    = 16;
   localparam int unsigned DefTimeout = 1000;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StReport
   } sched_state_e;

   typedef struct packed {
      logic leak;
      logic timeout;
   } rpt_flags_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/se_pair_scheduler_if.sv
// Bundle of command, SE issue/result and report signals around the scheduler.
// slave = scheduler side, master = test driver plus the two SE copies.
interface se_pair_scheduler_if
   import se_sched_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned INST_W = DefInstW,
   parameter int unsigned LAT_W  = DefLatW
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [INST_W-1:0] cmd_inst;
   logic [DATA_W-1:0] cmd_op1;
   logic [DATA_W-1:0] cmd_op2;
   logic [DATA_W-1:0] cmd_cond_a;
   logic [DATA_W-1:0] cmd_cond_b;

   logic              sea_in_valid;
   logic              seb_in_valid;
   logic              sea_in_ready;
   logic              seb_in_ready;
   logic [INST_W-1:0] se_in_inst;
   logic [DATA_W-1:0] se_in_op1;
   logic [DATA_W-1:0] se_in_op2;
   logic [DATA_W-1:0] sea_in_cond;
   logic [DATA_W-1:0] seb_in_cond;

   logic              sea_out_valid;
   logic              seb_out_valid;
   logic              sea_out_ready;
   logic              seb_out_ready;
   logic [DATA_W-1:0] sea_out_result;
   logic [DATA_W-1:0] seb_out_result;

   logic              rpt_valid;
   logic              rpt_ready;
   logic [DATA_W-1:0] rpt_result_a;
   logic [DATA_W-1:0] rpt_result_b;
   logic [LAT_W-1:0]  rpt_lat_a;
   logic [LAT_W-1:0]  rpt_lat_b;
   logic              rpt_timing_leak;
   logic              rpt_timeout;
   logic              leak_sticky;
   logic [7:0]        leak_count;

   modport slave (
      input  cmd_valid, cmd_inst, cmd_op1, cmd_op2, cmd_cond_a, cmd_cond_b,
      output cmd_ready,
      output sea_in_valid, seb_in_valid, se_in_inst, se_in_op1, se_in_op2,
      output sea_in_cond, seb_in_cond,
      input  sea_in_ready, seb_in_ready,
      input  sea_out_valid, seb_out_valid, sea_out_result, seb_out_result,
      output sea_out_ready, seb_out_ready,
      output rpt_valid, rpt_result_a, rpt_result_b, rpt_lat_a, rpt_lat_b,
      output rpt_timing_leak, rpt_timeout, leak_sticky, leak_count,
      input  rpt_ready
   );

   modport master (
      output cmd_valid, cmd_inst, cmd_op1, cmd_op2, cmd_cond_a, cmd_cond_b,
      input  cmd_ready,
      input  sea_in_valid, seb_in_valid, se_in_inst, se_in_op1, se_in_op2,
      input  sea_in_cond, seb_in_cond,
      output sea_in_ready, seb_in_ready,
      output sea_out_valid, seb_out_valid, sea_out_result, seb_out_result,
      input  sea_out_ready, seb_out_ready,
      input  rpt_valid, rpt_result_a, rpt_result_b, rpt_lat_a, rpt_lat_b,
      input  rpt_timing_leak, rpt_timeout, leak_sticky, leak_count,
      output rpt_ready
   );

endinterface

// File: rtl/se_copy_tracker.sv
// Per-copy issue/result bookkeeping: accept and done flags, captured result and latency.
// On a timeout exit an unfinished copy reports a zero result at the saturated cycle count.
module se_copy_tracker #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned LAT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              issuing,
   input  logic              active,
   input  logic              force_timeout,
   input  logic [LAT_W-1:0]  cyc,
   input  logic              in_ready,
   output logic              in_valid,
   input  logic              out_valid,
   input  logic [DATA_W-1:0] out_result,
   output logic              out_ready,
   output logic              acc_next,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [LAT_W-1:0]  lat
);

   logic              acc_q;
   logic              done_q;
   logic [DATA_W-1:0] result_q;
   logic [LAT_W-1:0]  lat_q;

   assign in_valid  = issuing & ~acc_q;
   // Result acceptance needs a registered accept, so issue and result never share a cycle.
   assign out_ready = active & acc_q & ~done_q;
   assign acc_next  = acc_q | (in_valid & in_ready);
   assign done      = done_q;
   assign result    = result_q;
   assign lat       = lat_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         lat_q    <= '0;
      end else if (start) begin
         acc_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         lat_q    <= '0;
      end else begin
         if (in_valid && in_ready) begin
            acc_q <= 1'b1;
         end
         if (out_valid && out_ready) begin
            done_q   <= 1'b1;
            result_q <= out_result;
            lat_q    <= cyc;
         end else if (force_timeout && !done_q) begin
            result_q <= '0;
            lat_q    <= cyc;
         end
      end
   end

endmodule

// File: rtl/se_pair_scheduler.sv
// Issues one command to two SE copies in lock-step, times both, and reports a leak verdict.
// Holds the sequencing FSM, the shared cycle counter and the leak statistics.
module se_pair_scheduler
   import se_sched_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned INST_W  = DefInstW,
   parameter int unsigned LAT_W   = DefLatW,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input logic clock,
   input logic reset,
   se_pair_scheduler_if.slave bus
);

   sched_state_e      state_q, state_d;
   logic [LAT_W-1:0]  cyc_q, cyc_d;
   logic [INST_W-1:0] inst_q;
   logic [DATA_W-1:0] op1_q, op2_q, cond_a_q, cond_b_q;
   logic              timeout_q, timeout_d;
   logic              leak_sticky_q, leak_sticky_d;
   logic [7:0]        leak_count_q, leak_count_d;

   logic              start, force_to, issuing, active, at_max, cmd_ready, rpt_valid;
   logic              acc_next_a, acc_next_b, done_a, done_b;
   logic [DATA_W-1:0] result_a, result_b;
   logic [LAT_W-1:0]  lat_a, lat_b;
   rpt_flags_t        flags;

   assign issuing = (state_q == StIssue);
   assign active  = (state_q == StIssue) || (state_q == StWait);
   assign at_max  = (cyc_q == LAT_W'(TIMEOUT));

   assign flags.leak    = (state_q == StReport) & done_a & done_b & (lat_a != lat_b);
   assign flags.timeout = timeout_q;

   always_comb begin
      state_d       = state_q;
      cyc_d         = cyc_q;
      timeout_d     = timeout_q;
      leak_sticky_d = leak_sticky_q;
      leak_count_d  = leak_count_q;
      start         = 1'b0;
      force_to      = 1'b0;
      cmd_ready     = 1'b0;
      rpt_valid     = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               start     = 1'b1;
               cyc_d     = '0;
               timeout_d = 1'b0;
               state_d   = StIssue;
            end
         end
         StIssue, StWait: begin
            cyc_d = at_max ? cyc_q : cyc_q + 1'b1;
            if (issuing ? (acc_next_a && acc_next_b) : (done_a && done_b)) begin
               state_d = issuing ? StWait : StReport;
            end else if (at_max) begin
               force_to  = 1'b1;
               timeout_d = 1'b1;
               state_d   = StReport;
            end
         end
         StReport: begin
            rpt_valid = 1'b1;
            if (bus.rpt_ready) begin
               state_d = StIdle;
               if (flags.leak) begin
                  leak_sticky_d = 1'b1;
                  leak_count_d  = sat_inc8(leak_count_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         cyc_q         <= '0;
         inst_q        <= '0;
         op1_q         <= '0;
         op2_q         <= '0;
         cond_a_q      <= '0;
         cond_b_q      <= '0;
         timeout_q     <= 1'b0;
         leak_sticky_q <= 1'b0;
         leak_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         cyc_q         <= cyc_d;
         timeout_q     <= timeout_d;
         leak_sticky_q <= leak_sticky_d;
         leak_count_q  <= leak_count_d;
         if (start) begin
            inst_q   <= bus.cmd_inst;
            op1_q    <= bus.cmd_op1;
            op2_q    <= bus.cmd_op2;
            cond_a_q <= bus.cmd_cond_a;
            cond_b_q <= bus.cmd_cond_b;
         end
      end
   end

   se_copy_tracker #(.DATA_W(DATA_W), .LAT_W(LAT_W)) u_copy_a (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .issuing       (issuing),
      .active        (active),
      .force_timeout (force_to),
      .cyc           (cyc_q),
      .in_ready      (bus.sea_in_ready),
      .in_valid      (bus.sea_in_valid),
      .out_valid     (bus.sea_out_valid),
      .out_result    (bus.sea_out_result),
      .out_ready     (bus.sea_out_ready),
      .acc_next      (acc_next_a),
      .done          (done_a),
      .result        (result_a),
      .lat           (lat_a)
   );

   se_copy_tracker #(.DATA_W(DATA_W), .LAT_W(LAT_W)) u_copy_b (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .issuing       (issuing),
      .active        (active),
      .force_timeout (force_to),
      .cyc           (cyc_q),
      .in_ready      (bus.seb_in_ready),
      .in_valid      (bus.seb_in_valid),
      .out_valid     (bus.seb_out_valid),
      .out_result    (bus.seb_out_result),
      .out_ready     (bus.seb_out_ready),
      .acc_next      (acc_next_b),
      .done          (done_b),
      .result        (result_b),
      .lat           (lat_b)
   );

   assign bus.cmd_ready       = cmd_ready;
   assign bus.rpt_valid       = rpt_valid;
   assign bus.se_in_inst      = inst_q;
   assign bus.se_in_op1       = op1_q;
   assign bus.se_in_op2       = op2_q;
   assign bus.sea_in_cond     = cond_a_q;
   assign bus.seb_in_cond     = cond_b_q;
   assign bus.rpt_result_a    = result_a;
   assign bus.rpt_result_b    = result_b;
   assign bus.rpt_lat_a       = lat_a;
   assign bus.rpt_lat_b       = lat_b;
   assign bus.rpt_timing_leak = flags.leak;
   assign bus.rpt_timeout     = flags.timeout;
   assign bus.leak_sticky     = leak_sticky_q;
   assign bus.leak_count      = leak_count_q;

endmodule

// File: tb/tb_se_pair_scheduler.sv
// Self-checking bench: directed commands, behavioural SE responders and a per-cycle report model.
module tb_se_pair_scheduler;
   localparam int unsigned DATA_W  = 128;
   localparam int unsigned INST_W  = 8;
   localparam int unsigned LAT_W   = 16;
   localparam int unsigned TIMEOUT = 20;
   localparam int          NEVER   = 999;

   logic clock = 1'b0;
   logic reset = 1'b0;

   se_pair_scheduler_if #(.DATA_W(DATA_W), .INST_W(INST_W), .LAT_W(LAT_W)) bus ();

   se_pair_scheduler #(
      .DATA_W (DATA_W),
      .INST_W (INST_W),
      .LAT_W  (LAT_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Parameters of the next command, copied to cur_* when the DUT accepts it.
   int nxt_acc_a, nxt_acc_b, nxt_ret_a, nxt_ret_b, nxt_bp;
   logic [DATA_W-1:0] nxt_val_a, nxt_val_b;
   int cur_acc_a, cur_acc_b, cur_ret_a, cur_ret_b, cur_bp;
   logic [DATA_W-1:0] cur_val_a, cur_val_b, cur_op1, cur_op2, cur_cond_a, cur_cond_b;
   logic [INST_W-1:0] cur_inst;

   bit busy, got_a, got_b, rpt_seen;
   int tcyc, gcyc, m_count, m_sticky;
   int cmd_hs_cnt, rpt_hs_cnt, cmd_hs_g, rpt_hs_g;
   int n_inv_a, n_inv_b, rpt_first, rpt_cycles;
   int snap_inv_a, snap_inv_b, snap_rpt_cycles;
   logic [DATA_W-1:0] snap_res_a, snap_res_b;
   logic [LAT_W-1:0]  snap_lat_a, snap_lat_b;
   logic snap_leak, snap_to;

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One step per cycle at negedge+2: compare outputs, drive SE/consumer, advance the model.
   task automatic cycle_loop();
      forever begin
         @(negedge clock);
         #2;
         gcyc++;
         if (!reset) begin
            busy = 0; tcyc = 0; m_sticky = 0; m_count = 0; got_a = 0; got_b = 0;
            bus.sea_in_ready = 0; bus.seb_in_ready = 0;
            bus.sea_out_valid = 0; bus.seb_out_valid = 0;
            bus.sea_out_result = '0; bus.seb_out_result = '0;
            bus.rpt_ready = 0;
         end else begin
            bit da, db, e_leak, e_to;
            int rep, la, lb;
            logic [DATA_W-1:0] ra, rb;
            da = cur_ret_a < int'(TIMEOUT);
            db = cur_ret_b < int'(TIMEOUT);
            rep = (da && db) ? ((cur_ret_a > cur_ret_b ? cur_ret_a : cur_ret_b) + 2)
                             : int'(TIMEOUT) + 1;
            la = da ? cur_ret_a : int'(TIMEOUT);
            lb = db ? cur_ret_b : int'(TIMEOUT);
            ra = da ? cur_val_a : '0;
            rb = db ? cur_val_b : '0;
            e_leak = da && db && (la != lb);
            e_to = !(da && db);

            chk("cmd_ready", bus.cmd_ready, !busy);
            chk("rpt_valid", bus.rpt_valid, busy && tcyc >= rep);
            chk("sea_in_valid", bus.sea_in_valid, busy && tcyc <= cur_acc_a);
            chk("seb_in_valid", bus.seb_in_valid, busy && tcyc <= cur_acc_b);
            chk("sea_out_ready", bus.sea_out_ready, busy && tcyc > cur_acc_a && tcyc < rep
                && tcyc <= (da ? cur_ret_a : int'(TIMEOUT)));
            chk("seb_out_ready", bus.seb_out_ready, busy && tcyc > cur_acc_b && tcyc < rep
                && tcyc <= (db ? cur_ret_b : int'(TIMEOUT)));
            chk("leak_sticky", bus.leak_sticky, m_sticky != 0);
            chk("leak_count", bus.leak_count, m_count);
            if (busy && (bus.sea_in_valid || bus.seb_in_valid)) begin
               chk("se_in_inst", bus.se_in_inst, cur_inst);
               chk("se_in_op1", bus.se_in_op1, cur_op1);
               chk("se_in_op2", bus.se_in_op2, cur_op2);
               chk("sea_in_cond", bus.sea_in_cond, cur_cond_a);
               chk("seb_in_cond", bus.seb_in_cond, cur_cond_b);
            end
            if (busy && tcyc >= rep) begin
               chk("rpt_result_a", bus.rpt_result_a, ra);
               chk("rpt_result_b", bus.rpt_result_b, rb);
               chk("rpt_lat_a", bus.rpt_lat_a, la);
               chk("rpt_lat_b", bus.rpt_lat_b, lb);
               chk("rpt_timing_leak", bus.rpt_timing_leak, e_leak);
               chk("rpt_timeout", bus.rpt_timeout, e_to);
            end

            bus.sea_in_ready   = busy && tcyc >= cur_acc_a;
            bus.seb_in_ready   = busy && tcyc >= cur_acc_b;
            bus.sea_out_valid  = busy && tcyc >= cur_ret_a && !got_a;
            bus.seb_out_valid  = busy && tcyc >= cur_ret_b && !got_b;
            bus.sea_out_result = bus.sea_out_valid ? cur_val_a : ~cur_val_a;
            bus.seb_out_result = bus.seb_out_valid ? cur_val_b : ~cur_val_b;
            bus.rpt_ready      = busy && tcyc >= rep + cur_bp;

            if (bus.sea_in_valid) n_inv_a++;
            if (bus.seb_in_valid) n_inv_b++;
            if (bus.rpt_valid) begin
               if (!rpt_seen) rpt_first = tcyc;
               rpt_seen = 1;
               rpt_cycles++;
            end
            if (bus.sea_out_valid && bus.sea_out_ready) got_a = 1;
            if (bus.seb_out_valid && bus.seb_out_ready) got_b = 1;

            if (bus.rpt_valid && bus.rpt_ready) begin
               snap_res_a = bus.rpt_result_a; snap_res_b = bus.rpt_result_b;
               snap_lat_a = bus.rpt_lat_a;    snap_lat_b = bus.rpt_lat_b;
               snap_leak  = bus.rpt_timing_leak; snap_to = bus.rpt_timeout;
               snap_inv_a = n_inv_a; snap_inv_b = n_inv_b; snap_rpt_cycles = rpt_cycles;
               if (e_leak) begin
                  m_sticky = 1;
                  m_count = (m_count < 255) ? m_count + 1 : 255;
               end
               busy = 0;
               rpt_hs_cnt++;
               rpt_hs_g = gcyc;
            end else if (bus.cmd_valid && bus.cmd_ready) begin
               cur_acc_a = nxt_acc_a; cur_acc_b = nxt_acc_b;
               cur_ret_a = nxt_ret_a; cur_ret_b = nxt_ret_b;
               cur_val_a = nxt_val_a; cur_val_b = nxt_val_b; cur_bp = nxt_bp;
               cur_inst = bus.cmd_inst; cur_op1 = bus.cmd_op1; cur_op2 = bus.cmd_op2;
               cur_cond_a = bus.cmd_cond_a; cur_cond_b = bus.cmd_cond_b;
               busy = 1; tcyc = 0; got_a = 0; got_b = 0;
               n_inv_a = 0; n_inv_b = 0; rpt_seen = 0; rpt_cycles = 0;
               cmd_hs_cnt++;
               cmd_hs_g = gcyc;
            end else if (busy) begin
               tcyc++;
            end
         end
      end
   endtask

   task automatic issue(input int acc_a, input int acc_b, input int ret_a, input int ret_b,
                        input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                        input int bp, input int seed);
      @(negedge clock);
      #1;
      nxt_acc_a = acc_a; nxt_acc_b = acc_b; nxt_ret_a = ret_a; nxt_ret_b = ret_b;
      nxt_val_a = va; nxt_val_b = vb; nxt_bp = bp;
      bus.cmd_inst   = INST_W'(seed + 3);
      bus.cmd_op1    = {4{32'hA5A5_0000 + 32'(seed)}};
      bus.cmd_op2    = {4{32'h5A5A_0000 + 32'(seed)}};
      bus.cmd_cond_a = {4{32'hC0DE_0000 + 32'(seed)}};
      bus.cmd_cond_b = {4{32'hBEEF_0000 + 32'(seed)}};
      bus.cmd_valid  = 1'b1;
   endtask

   task automatic wait_cmd(input int base);
      int n;
      n = 0;
      while (cmd_hs_cnt == base && n < 200) begin
         @(negedge clock);
         #1;
         n++;
      end
      bus.cmd_valid = 1'b0;
      if (cmd_hs_cnt == base) begin
         checks++; failures++;
         $display("FAIL cmd_accept_timeout: got none expected handshake");
      end
   endtask

   task automatic wait_rpt(input int base);
      int n;
      n = 0;
      while (rpt_hs_cnt == base && n < 200) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (rpt_hs_cnt == base) begin
         checks++; failures++;
         $display("FAIL report_timeout: got none expected report handshake");
      end
   endtask

   task automatic run(input int acc_a, input int acc_b, input int ret_a, input int ret_b,
                      input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                      input int bp, input int seed);
      int cb, rb;
      cb = cmd_hs_cnt;
      rb = rpt_hs_cnt;
      issue(acc_a, acc_b, ret_a, ret_b, va, vb, bp, seed);
      wait_cmd(cb);
      wait_rpt(rb);
   endtask

   initial begin
      int cb, rb, n;
      bus.cmd_valid = 0; bus.cmd_inst = '0; bus.cmd_op1 = '0; bus.cmd_op2 = '0;
      bus.cmd_cond_a = '0; bus.cmd_cond_b = '0;
      bus.sea_in_ready = 0; bus.seb_in_ready = 0; bus.sea_out_valid = 0; bus.seb_out_valid = 0;
      bus.sea_out_result = '0; bus.seb_out_result = '0; bus.rpt_ready = 0;
      cur_acc_a = 0; cur_acc_b = 0; cur_ret_a = 0; cur_ret_b = 0; cur_bp = 0;
      fork
         cycle_loop();
      join_none

      repeat (3) @(negedge clock);
      #1;
      chk("reset_cmd_ready", bus.cmd_ready, 1);
      chk("reset_rpt_valid", bus.rpt_valid, 0);
      chk("reset_sea_in_valid", bus.sea_in_valid, 0);
      chk("reset_leak_count", bus.leak_count, 0);
      reset = 1'b1;

      // Equal latency, no leak.
      run(0, 0, 7, 7, 128'h55, 128'h55, 0, 1);
      chk("eq_lat_a", snap_lat_a, 7);
      chk("eq_lat_b", snap_lat_b, 7);
      chk("eq_result_a", snap_res_a, 128'h55);
      chk("eq_leak", snap_leak, 0);
      chk("eq_rpt_first_cyc", rpt_first, 9);
      chk("eq_leak_count", bus.leak_count, 0);

      // Secret-dependent latency.
      run(0, 0, 10, 14, 128'h11, 128'h22, 0, 2);
      chk("leak_flag", snap_leak, 1);
      chk("leak_lat_b", snap_lat_b, 14);
      chk("leak_sticky_after", bus.leak_sticky, 1);
      chk("leak_count_after", bus.leak_count, 1);

      // Skewed acceptance.
      run(3, 0, 8, 8, 128'h77, 128'h77, 0, 3);
      chk("skew_inv_a_cycles", snap_inv_a, 4);
      chk("skew_inv_b_cycles", snap_inv_b, 1);

      // Copy B never returns.
      run(0, 0, 5, NEVER, 128'h99, 128'h98, 0, 4);
      chk("to_rpt_first_cyc", rpt_first, 21);
      chk("to_lat_a", snap_lat_a, 5);
      chk("to_lat_b", snap_lat_b, 20);
      chk("to_result_b", snap_res_b, 0);
      chk("to_timeout", snap_to, 1);
      chk("to_leak", snap_leak, 0);

      // Report backpressure with the next command already offered.
      cb = cmd_hs_cnt;
      rb = rpt_hs_cnt;
      issue(0, 0, 6, 9, 128'hA1, 128'hA2, 5, 5);
      wait_cmd(cb);
      n = 0;
      while (!rpt_seen && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("bp_report_seen", rpt_seen, 1);
      cb = cmd_hs_cnt;
      issue(0, 0, 4, 4, 128'hB1, 128'hB1, 0, 6);
      wait_cmd(cb);
      chk("bp_accept_gap", cmd_hs_g - rpt_hs_g, 1);
      chk("bp_rpt_cycles", snap_rpt_cycles, 6);
      wait_rpt(rb + 1);
      chk("bp_leak_count", bus.leak_count, 2);

      // Asynchronous reset while waiting on results.
      cb = cmd_hs_cnt;
      issue(0, 0, NEVER, NEVER, 128'h1, 128'h2, 0, 7);
      wait_cmd(cb);
      repeat (5) @(negedge clock);
      #3;
      chk("pre_rst_out_ready", bus.sea_out_ready, 1);
      reset = 1'b0;
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_rpt_valid", bus.rpt_valid, 0);
      chk("rst_sea_out_ready", bus.sea_out_ready, 0);
      chk("rst_seb_in_valid", bus.seb_in_valid, 0);
      chk("rst_leak_sticky", bus.leak_sticky, 0);
      chk("rst_leak_count", bus.leak_count, 0);
      chk("rst_se_in_op1", bus.se_in_op1, 0);
      chk("rst_rpt_lat_b", bus.rpt_lat_b, 0);
      @(negedge clock);
      #3;
      reset = 1'b1;

      // Leak counter saturation.
      for (int i = 0; i < 256; i++) begin
         run(0, 0, 3, 4, 128'hC, 128'hD, 0, 8 + i);
         if (i == 254) chk("sat_count_255", bus.leak_count, 255);
      end
      chk("sat_count_final", bus.leak_count, 255);
      chk("sat_sticky", bus.leak_sticky, 1);

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
